// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus: fetch handshake, decode handshake, redirect flush
// and the back-pressure counter exported to performance monitoring.
interface if_id_stage_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned INS_W = 32,
  parameter int unsigned CNT_W = 16
);
  logic             IF_valid;
  logic             IF_ready;
  logic [PC_W-1:0]  IF_PC;
  logic [INS_W-1:0] IF_ins;
  logic             flush;
  logic             ID_valid;
  logic             ID_ready;
  logic [PC_W-1:0]  ID_PC;
  logic [INS_W-1:0] ID_ins;
  logic [CNT_W-1:0] stall_cnt;

  // Environment view: fetch unit, decode unit and redirect logic
  modport master (
    output IF_valid, IF_PC, IF_ins, flush, ID_ready,
    input  IF_ready, ID_valid, ID_PC, ID_ins, stall_cnt
  );

  // Pipeline stage view
  modport slave (
    input  IF_valid, IF_PC, IF_ins, flush, ID_ready,
    output IF_ready, ID_valid, ID_PC, ID_ins, stall_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. With SKID=1 a second (skid) entry absorbs the
// beat accepted while decode stalls, so IF_ready can come from a flop and
// never depends combinationally on ID_ready. With SKID=0 the stage is a
// single register whose IF_ready looks through to ID_ready.
// Empty stage presents NOP_INS to decode; ID_PC keeps its last value.
module if_id_stage #(
  parameter int unsigned      PC_W    = 32,
  parameter int unsigned      INS_W   = 32,
  parameter logic [INS_W-1:0] NOP_INS = {INS_W{1'b0}},
  parameter bit               SKID    = 1'b1,
  parameter int unsigned      CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_e;

  state_e           state_r;
  logic             id_valid_r;
  logic             if_ready_r;
  logic [PC_W-1:0]  main_pc_r;
  logic [INS_W-1:0] main_ins_r;
  logic [PC_W-1:0]  skid_pc_r;
  logic [INS_W-1:0] skid_ins_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic if_ready_s;
  logic in_xfer_s;
  logic out_xfer_s;

  // Fetch-side ready and the two handshake transfers
  always_comb begin
    if_ready_s = 1'b0;
    if (SKID) begin
      if_ready_s = if_ready_r;
    end else begin
      if_ready_s = !id_valid_r || bus.ID_ready;
    end
    in_xfer_s  = bus.IF_valid && if_ready_s;
    out_xfer_s = id_valid_r && bus.ID_ready;
  end

  // Occupancy FSM with main/skid entries and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      id_valid_r <= 1'b0;
      if_ready_r <= 1'b1;
      main_pc_r  <= {PC_W{1'b0}};
      main_ins_r <= NOP_INS;
      skid_pc_r  <= {PC_W{1'b0}};
      skid_ins_r <= NOP_INS;
    end else if (bus.flush) begin
      // Redirect: drop everything held and whatever fetch offers now
      state_r    <= ST_EMPTY;
      id_valid_r <= 1'b0;
      if_ready_r <= 1'b1;
      main_ins_r <= NOP_INS;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_r    <= ST_FULL;
            id_valid_r <= 1'b1;
            main_pc_r  <= bus.IF_PC;
            main_ins_r <= bus.IF_ins;
          end
        end
        ST_FULL: begin
          if (in_xfer_s && out_xfer_s) begin
            main_pc_r  <= bus.IF_PC;
            main_ins_r <= bus.IF_ins;
          end else if (in_xfer_s) begin
            // Only reachable with a skid entry: decode stalled this cycle
            if (SKID) begin
              state_r    <= ST_SKID_FULL;
              if_ready_r <= 1'b0;
              skid_pc_r  <= bus.IF_PC;
              skid_ins_r <= bus.IF_ins;
            end
          end else if (out_xfer_s) begin
            state_r    <= ST_EMPTY;
            id_valid_r <= 1'b0;
            main_ins_r <= NOP_INS;
          end
        end
        ST_SKID_FULL: begin
          if (out_xfer_s) begin
            state_r    <= ST_FULL;
            if_ready_r <= 1'b1;
            main_pc_r  <= skid_pc_r;
            main_ins_r <= skid_ins_r;
          end
        end
        default: begin
          state_r    <= ST_EMPTY;
          id_valid_r <= 1'b0;
          if_ready_r <= 1'b1;
          main_ins_r <= NOP_INS;
        end
      endcase
    end
  end

  // Saturating count of cycles where decode back-pressures a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (id_valid_r && !bus.ID_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.IF_ready  = if_ready_s;
  assign bus.ID_valid  = id_valid_r;
  assign bus.ID_PC     = main_pc_r;
  assign bus.ID_ins    = main_ins_r;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: three instances (skid, single register, skid with
// 4-bit stall counter) share one stimulus stream; a queue-style occupancy
// model per instance supplies expected outputs.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_ins;

  int n_checks;
  int n_errors;

  if_id_stage_if #(.PC_W(32), .INS_W(32), .CNT_W(16)) ifa ();
  if_id_stage_if #(.PC_W(32), .INS_W(32), .CNT_W(16)) ifb ();
  if_id_stage_if #(.PC_W(32), .INS_W(32), .CNT_W(4))  ifc ();

  assign ifa.IF_valid = if_valid;
  assign ifa.IF_PC    = if_pc;
  assign ifa.IF_ins   = if_ins;
  assign ifa.flush    = flush;
  assign ifa.ID_ready = id_ready;
  assign ifb.IF_valid = if_valid;
  assign ifb.IF_PC    = if_pc;
  assign ifb.IF_ins   = if_ins;
  assign ifb.flush    = flush;
  assign ifb.ID_ready = id_ready;
  assign ifc.IF_valid = if_valid;
  assign ifc.IF_PC    = if_pc;
  assign ifc.IF_ins   = if_ins;
  assign ifc.flush    = flush;
  assign ifc.ID_ready = id_ready;

  if_id_stage #(.PC_W(32), .INS_W(32), .NOP_INS(NOP), .SKID(1'b1), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  if_id_stage #(.PC_W(32), .INS_W(32), .NOP_INS(NOP), .SKID(1'b0), .CNT_W(16))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  if_id_stage #(.PC_W(32), .INS_W(32), .NOP_INS(NOP), .SKID(1'b1), .CNT_W(4))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic        obs_valid [3];
  logic        obs_rdy   [3];
  logic [31:0] obs_pc    [3];
  logic [31:0] obs_ins   [3];
  logic [31:0] obs_cnt   [3];

  assign obs_valid[0] = ifa.ID_valid;
  assign obs_valid[1] = ifb.ID_valid;
  assign obs_valid[2] = ifc.ID_valid;
  assign obs_rdy[0]   = ifa.IF_ready;
  assign obs_rdy[1]   = ifb.IF_ready;
  assign obs_rdy[2]   = ifc.IF_ready;
  assign obs_pc[0]    = ifa.ID_PC;
  assign obs_pc[1]    = ifb.ID_PC;
  assign obs_pc[2]    = ifc.ID_PC;
  assign obs_ins[0]   = ifa.ID_ins;
  assign obs_ins[1]   = ifb.ID_ins;
  assign obs_ins[2]   = ifc.ID_ins;
  assign obs_cnt[0]   = {16'd0, ifa.stall_cnt};
  assign obs_cnt[1]   = {16'd0, ifb.stall_cnt};
  assign obs_cnt[2]   = {28'd0, ifc.stall_cnt};

  // Reference model: FIFO of held beats per instance (capacity 2 with skid, 1 without)
  logic [31:0] m_pc   [3][2];
  logic [31:0] m_ins  [3][2];
  int          m_sz   [3];
  logic [31:0] m_last [3];
  int          m_cnt  [3];
  logic        m_acc  [3];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int cnt_max(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic exp_rdy(int k);
    if (k == 1) return (m_sz[k] == 0) || id_ready;
    return m_sz[k] < 2;
  endfunction

  function automatic logic [31:0] exp_ins(int k);
    return (m_sz[k] > 0) ? m_ins[k][0] : NOP;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      logic vin;
      logic vout;
      vin  = if_valid && exp_rdy(k) && !flush && !rst;
      vout = (m_sz[k] > 0) && id_ready;
      m_acc[k] = vin;
      if (rst) begin
        m_sz[k]   = 0;
        m_last[k] = 32'h0;
        m_cnt[k]  = 0;
      end else begin
        if ((m_sz[k] > 0) && !id_ready && (m_cnt[k] < cnt_max(k))) m_cnt[k]++;
        if (flush) begin
          m_sz[k] = 0;
        end else begin
          if (vout) begin
            m_pc[k][0]  = m_pc[k][1];
            m_ins[k][0] = m_ins[k][1];
            m_sz[k]--;
          end
          if (vin) begin
            m_pc[k][m_sz[k]]  = if_pc;
            m_ins[k][m_sz[k]] = if_ins;
            m_sz[k]++;
          end
        end
        if (m_sz[k] > 0) m_last[k] = m_pc[k][0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 5;
      if (obs_valid[k] !== 1'b0) begin n_errors++; $display("FAIL reset_valid[%0d]: got %0b want 0", k, obs_valid[k]); end
      if (obs_pc[k] !== 32'h0) begin n_errors++; $display("FAIL reset_pc[%0d]: got %h want 0", k, obs_pc[k]); end
      if (obs_ins[k] !== NOP) begin n_errors++; $display("FAIL reset_ins[%0d]: got %h want %h", k, obs_ins[k], NOP); end
      if (obs_rdy[k] !== 1'b1) begin n_errors++; $display("FAIL reset_rdy[%0d]: got %0b want 1", k, obs_rdy[k]); end
      if (obs_cnt[k] !== 32'd0) begin n_errors++; $display("FAIL reset_cnt[%0d]: got %0d want 0", k, obs_cnt[k]); end
    end
  endtask

  task automatic test_first_beat();
    do_reset();
    if_valid = 1'b1; if_pc = 32'h100; if_ins = 32'h2008_0005; id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 3;
      if (obs_valid[k] !== 1'b1) begin n_errors++; $display("FAIL first_valid[%0d]: got %0b want 1", k, obs_valid[k]); end
      if (obs_pc[k] !== 32'h100) begin n_errors++; $display("FAIL first_pc[%0d]: got %h want 00000100", k, obs_pc[k]); end
      if (obs_ins[k] !== 32'h2008_0005) begin n_errors++; $display("FAIL first_ins[%0d]: got %h want 20080005", k, obs_ins[k]); end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 3;
      if (obs_valid[k] !== 1'b0) begin n_errors++; $display("FAIL drain_valid[%0d]: got %0b want 0", k, obs_valid[k]); end
      if (obs_ins[k] !== NOP) begin n_errors++; $display("FAIL drain_ins[%0d]: got %h want %h", k, obs_ins[k], NOP); end
      if (obs_pc[k] !== 32'h100) begin n_errors++; $display("FAIL drain_pc_hold[%0d]: got %h want 00000100", k, obs_pc[k]); end
    end
  endtask

  task automatic test_skid_fill();
    logic [31:0] got [$];
    do_reset();
    id_ready = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc  = 32'h100 + 32'(4 * i);
      if_ins = 32'hA000_0000 | if_pc;
      tick();
    end
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks += 4;
        if (obs_valid[0] !== 1'b1) begin n_errors++; $display("FAIL skid_valid: got %0b want 1", obs_valid[0]); end
        if (obs_pc[0] !== 32'h100) begin n_errors++; $display("FAIL skid_main_pc: got %h want 00000100", obs_pc[0]); end
        if (obs_rdy[0] !== 1'b0) begin n_errors++; $display("FAIL skid_if_ready: got %0b want 0", obs_rdy[0]); end
        if (obs_cnt[0] !== 32'd2) begin n_errors++; $display("FAIL skid_stall_cnt: got %0d want 2", obs_cnt[0]); end
      end
      if (obs_valid[0]) got.push_back(obs_pc[0]);
      tick();
      if (m_acc[0]) if_valid = 1'b0;
    end
    @(negedge clk);
    n_checks += 2;
    if (got.size() !== 3) begin n_errors++; $display("FAIL skid_order_len: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== 32'h100 + 32'(4 * i)) begin
          n_errors++; $display("FAIL skid_order[%0d]: got %h want %h", i, got[i], 32'h100 + 32'(4 * i));
        end
      end
    end
    if (obs_cnt[0] !== 32'd2) begin n_errors++; $display("FAIL skid_stall_final: got %0d want 2", obs_cnt[0]); end
  endtask

  task automatic test_flush_skid();
    do_reset();
    id_ready = 1'b0; if_valid = 1'b1;
    if_pc = 32'h100; if_ins = 32'hB000_0100; tick();
    if_pc = 32'h104; if_ins = 32'hB000_0104; tick();
    @(negedge clk);
    n_checks++;
    if (obs_rdy[0] !== 1'b0) begin n_errors++; $display("FAIL flush_pre_rdy: got %0b want 0", obs_rdy[0]); end
    flush = 1'b1; if_pc = 32'h200; if_ins = 32'hB000_0200;
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    n_checks += 5;
    if (obs_valid[0] !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %0b want 0", obs_valid[0]); end
    if (obs_ins[0] !== NOP) begin n_errors++; $display("FAIL flush_ins: got %h want %h", obs_ins[0], NOP); end
    if (obs_rdy[0] !== 1'b1) begin n_errors++; $display("FAIL flush_rdy: got %0b want 1", obs_rdy[0]); end
    if (obs_cnt[0] !== 32'd2) begin n_errors++; $display("FAIL flush_stall_cnt: got %0d want 2", obs_cnt[0]); end
    if (obs_pc[0] !== 32'h100) begin n_errors++; $display("FAIL flush_pc_hold: got %h want 00000100", obs_pc[0]); end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (obs_valid[0] !== 1'b0 || obs_pc[0] === 32'h200) begin
        n_errors++; $display("FAIL flush_leak: valid %0b pc %h, want invalid and not 00000200", obs_valid[0], obs_pc[0]);
      end
    end
    // Beat offered to an empty, ready stage during flush is dropped too
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h204; if_ins = 32'hB000_0204;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_valid[k] !== 1'b0) begin n_errors++; $display("FAIL flush_drop[%0d]: got valid %0b want 0", k, obs_valid[k]); end
    end
  endtask

  task automatic test_noskid_toggle();
    logic [31:0] nxt_in;
    logic [31:0] nxt_out;
    do_reset();
    nxt_in = 32'h1000; nxt_out = 32'h1000;
    for (int c = 0; c < 40; c++) begin
      id_ready = (c % 2 == 0);
      if_valid = 1'b1; if_pc = nxt_in; if_ins = ~nxt_in;
      @(negedge clk);
      n_checks++;
      if (obs_rdy[1] !== exp_rdy(1)) begin n_errors++; $display("FAIL noskid_rdy @%0d: got %0b want %0b", c, obs_rdy[1], exp_rdy(1)); end
      if (obs_valid[1] && id_ready) begin
        n_checks++;
        if (obs_pc[1] !== nxt_out) begin n_errors++; $display("FAIL noskid_seq @%0d: got %h want %h", c, obs_pc[1], nxt_out); end
        nxt_out = nxt_out + 32'd4;
      end
      tick();
      if (m_acc[1]) nxt_in = nxt_in + 32'd4;
    end
    if_valid = 1'b0;
    n_checks++;
    if (nxt_out < 32'h1000 + 32'd60) begin n_errors++; $display("FAIL noskid_throughput: got next %h want >= 0000103c", nxt_out); end
  endtask

  task automatic test_cnt_sat();
    do_reset();
    if_valid = 1'b1; if_pc = 32'h400; if_ins = 32'hC000_0400; id_ready = 1'b0;
    tick();
    if_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge clk);
      n_checks += 2;
      if (obs_cnt[2] !== 32'((i < 15) ? i : 15)) begin n_errors++; $display("FAIL cnt4_sat @%0d: got %0d want %0d", i, obs_cnt[2], (i < 15) ? i : 15); end
      if (obs_cnt[0] !== 32'(i)) begin n_errors++; $display("FAIL cnt16 @%0d: got %0d want %0d", i, obs_cnt[0], i); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_cnt[k] !== 32'd0) begin n_errors++; $display("FAIL cnt_rst[%0d]: got %0d want 0", k, obs_cnt[k]); end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    if_valid = 1'b1; if_pc = 32'h300; if_ins = 32'hD000_0300; id_ready = 1'b0;
    tick();
    if_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks += 2;
    if (obs_valid[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_valid: got %0b want 1", obs_valid[0]); end
    if (obs_cnt[0] !== 32'd2) begin n_errors++; $display("FAIL rstmid_pre_cnt: got %0d want 2", obs_cnt[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 5;
      if (obs_valid[k] !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid[%0d]: got %0b want 0", k, obs_valid[k]); end
      if (obs_pc[k] !== 32'h0) begin n_errors++; $display("FAIL rstmid_pc[%0d]: got %h want 0", k, obs_pc[k]); end
      if (obs_ins[k] !== NOP) begin n_errors++; $display("FAIL rstmid_ins[%0d]: got %h want %h", k, obs_ins[k], NOP); end
      if (obs_cnt[k] !== 32'd0) begin n_errors++; $display("FAIL rstmid_cnt[%0d]: got %0d want 0", k, obs_cnt[k]); end
      if (obs_rdy[k] !== 1'b1) begin n_errors++; $display("FAIL rstmid_rdy[%0d]: got %0b want 1", k, obs_rdy[k]); end
    end
    if_valid = 1'b1; if_pc = 32'h304; if_ins = 32'hD000_0304;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 2;
      if (obs_valid[k] !== 1'b1) begin n_errors++; $display("FAIL rstmid_accept_valid[%0d]: got %0b want 1", k, obs_valid[k]); end
      if (obs_pc[k] !== 32'h304) begin n_errors++; $display("FAIL rstmid_accept_pc[%0d]: got %h want 00000304", k, obs_pc[k]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      id_ready = (c < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      if_pc    = $urandom;
      if_ins   = $urandom;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks += 5;
        if (obs_valid[k] !== (m_sz[k] > 0)) begin n_errors++; $display("FAIL rand_valid[%0d] @%0d: got %0b want %0b", k, c, obs_valid[k], m_sz[k] > 0); end
        if (obs_pc[k] !== m_last[k]) begin n_errors++; $display("FAIL rand_pc[%0d] @%0d: got %h want %h", k, c, obs_pc[k], m_last[k]); end
        if (obs_ins[k] !== exp_ins(k)) begin n_errors++; $display("FAIL rand_ins[%0d] @%0d: got %h want %h", k, c, obs_ins[k], exp_ins(k)); end
        if (obs_rdy[k] !== exp_rdy(k)) begin n_errors++; $display("FAIL rand_rdy[%0d] @%0d: got %0b want %0b", k, c, obs_rdy[k], exp_rdy(k)); end
        if (obs_cnt[k] !== 32'(m_cnt[k])) begin n_errors++; $display("FAIL rand_cnt[%0d] @%0d: got %0d want %0d", k, c, obs_cnt[k], m_cnt[k]); end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
  endtask

  // Test sequence
  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = 32'h0; if_ins = 32'h0;
    test_reset();
    test_first_beat();
    test_skid_fill();
    test_flush_skid();
    test_noskid_toggle();
    test_cnt_sat();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter path.
REQ-002 Parameter INS_W, default 32, width of the instruction path.
REQ-003 Parameter NOP_INS, default 32'h00000000 (INS_W bits), bubble instruction driven when the stage holds no valid entry.
REQ-004 Parameter SKID, default 1; 1 = two-entry skid buffer with registered IF_ready, 0 = single register with combinational IF_ready.
REQ-005 Parameter CNT_W, default 16, width of the stall counter.
REQ-006 clk  input  1  sole clock; all state updates on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-008 IF_valid  input  1  fetch side presents a beat.
REQ-009 IF_ready  output  1  stage accepts a beat this cycle.
REQ-010 IF_PC  input  PC_W  fetched PC.
REQ-011 IF_ins  input  INS_W  fetched instruction.
REQ-012 flush  input  1  discard all held and incoming beats (branch/jump redirect).
REQ-013 ID_valid  output  1  ID_PC/ID_ins hold a valid beat.
REQ-014 ID_ready  input  1  decode consumes the beat this cycle.
REQ-015 ID_PC  output  PC_W  registered PC to decode.
REQ-016 ID_ins  output  INS_W  registered instruction to decode.
REQ-017 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-018 Input transfer = IF_valid && IF_ready; output transfer = ID_valid && ID_ready, both evaluated at posedge clk.
REQ-019 Beats leave in acceptance order; no beat is duplicated or dropped except by flush or rst.
REQ-020 Latency: beat accepted into an empty stage in cycle N appears on ID_valid/ID_PC/ID_ins in cycle N+1.
REQ-021 SKID=1 states: EMPTY (no entry), FULL (main register valid), SKID_FULL (main and skid register valid).
REQ-022 EMPTY: input transfer -> FULL, main loads IF_PC/IF_ins; else stay.
REQ-023 FULL: in && out -> FULL with main reloaded; in && !out -> SKID_FULL with skid loaded; !in && out -> EMPTY; neither -> hold.
REQ-024 SKID_FULL: out -> FULL with main <= skid; else hold; no input transfer possible in this state.
REQ-025 SKID=1: IF_ready is a register output, 1 in EMPTY and FULL, 0 in SKID_FULL; no combinational path from ID_ready to IF_ready.
REQ-026 SKID=0: states EMPTY/FULL only; IF_ready = !ID_valid || ID_ready; simultaneous in/out reloads main.
REQ-027 ID_valid = 1 exactly in FULL and SKID_FULL; ID_PC/ID_ins are the main register (oldest beat).
REQ-028 Whenever ID_valid=0, ID_ins = NOP_INS; ID_PC retains its last value.
REQ-029 ID_PC/ID_ins are stable while ID_valid=1 and ID_ready=0.
REQ-030 flush=1: next state EMPTY, skid invalidated, ID_valid=0, ID_ins=NOP_INS, IF_ready=1; a beat offered in the flush cycle is discarded even if IF_ready=1.
REQ-031 stall_cnt increments by 1 each cycle with ID_valid=1 and ID_ready=0, saturates at 2^CNT_W-1, unaffected by flush.
REQ-032 rst has priority over flush; flush over all handshakes.

Reset
REQ-033 rst=1 at posedge: state EMPTY, ID_valid=0, ID_PC=0, ID_ins=NOP_INS, IF_ready=1, stall_cnt=0, skid register invalid.
REQ-034 rst asserted mid-operation discards all held beats, identical outcome to REQ-033; first acceptance possible the cycle after rst deasserts.

Verification
REQ-035 rst, then IF_valid=1, IF_PC=0x100, IF_ins=0x20080005, ID_ready=1 -> next cycle ID_valid=1, ID_PC=0x100, ID_ins=0x20080005.
REQ-036 SKID=1, ID_ready=0, offer 0x100, 0x104, 0x108 back-to-back -> 0x100 in main, 0x104 in skid, IF_ready=0, 0x108 held; ID_ready=1 then delivers 0x100, 0x104, 0x108 in order, stall_cnt counts the stalled cycles exactly.
REQ-037 SKID_FULL with flush=1 and IF_valid=1 (PC 0x200) -> next cycle ID_valid=0, ID_ins=NOP_INS, IF_ready=1; 0x200 never appears on ID.
REQ-038 SKID=0, continuous IF_valid and ID_ready toggling 1/0 -> IF_ready follows !ID_valid||ID_ready same cycle; output PC stream strictly sequential, no gaps or repeats.
REQ-039 CNT_W=4, hold ID_valid=1, ID_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; rst -> 0.
REQ-040 rst asserted while FULL with flush=0 -> next cycle ID_valid=0, ID_PC=0, ID_ins=NOP_INS, stall_cnt=0.
